// File: rtl/gemm_stream_pkg.sv
// Shared types and sizing for the GEMM stream master: FSM states, per-phase
// word counts and the counter widths derived from them.
package gemm_stream_pkg;

  localparam int PRM_WORDS = 32;
  localparam int SRC_WORDS = 32;
  localparam int DST_WORDS = 16;

  localparam int MAX_WORDS = (PRM_WORDS > SRC_WORDS) ? PRM_WORDS : SRC_WORDS;
  // Word counters must hold the full phase length, not just the last index.
  localparam int WCNT_W    = $clog2(MAX_WORDS + 1);
  localparam int DCNT_W    = $clog2(DST_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRM   = 3'd1,
    GAP   = 3'd2,
    SRC   = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that sits between the memory read port and the outgoing stream;
// the head word stays put until it is popped.
module stream_skid_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [1:0]    count
);

  logic [DW-1:0] entry [2];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign pop_data = entry[rd_ptr];

endmodule

// File: rtl/gemm_stream_master.sv
// Host-side GEMM batch initiator: streams weights then per-batch sources from
// word memory, and writes each batch's result stream back to memory.
module gemm_stream_master
  import gemm_stream_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    nbatch,
  input  logic [AW-1:0] prm_base,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          matw,
  output logic          run,
  output logic          src_valid,
  input  logic          src_ready,
  output logic [DW-1:0] src_data,
  input  logic          dst_valid,
  output logic          dst_ready,
  input  logic [DW-1:0] dst_data,
  output logic [2:0]    dbg_state
);

  // Handshakes: a word moves on any cycle where valid & ready are both high.
  // src_valid/src_data hold steady until taken; src_valid only rises in PRM or
  // SRC. dst_ready is high only in DRAIN, and each dst handshake writes memory
  // in that same cycle.

  state_t            state;
  state_t            state_nx;
  logic [7:0]        nbatch_q;
  logic [7:0]        b_cnt;
  logic [AW-1:0]     src_base_q;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [WCNT_W-1:0] iss_cnt;
  logic [WCNT_W-1:0] acc_cnt;
  logic [DCNT_W-1:0] dst_cnt;
  logic              inflight;

  logic [1:0]        fifo_count;
  logic [DW-1:0]     fifo_head;

  logic              stream_phase;
  logic [WCNT_W-1:0] phase_words;
  logic              src_xfer;
  logic              last_xfer;
  logic              wr_fire;
  logic              last_wr;
  logic [2:0]        level;
  logic              issue;

  assign stream_phase = (state == PRM) || (state == SRC);
  assign phase_words  = (state == PRM) ? WCNT_W'(PRM_WORDS) : WCNT_W'(SRC_WORDS);
  assign src_valid    = stream_phase && (fifo_count != 2'd0);
  assign src_xfer     = src_valid && src_ready;
  assign last_xfer    = src_xfer && (acc_cnt == phase_words - WCNT_W'(1));
  assign dst_ready    = (state == DRAIN);
  assign wr_fire      = dst_valid && dst_ready;
  assign last_wr      = wr_fire && (dst_cnt == DCNT_W'(DST_WORDS - 1));

  // Occupancy is counted after this cycle's pop so a steady stream can keep
  // one read in flight every cycle while never exceeding two words held.
  assign level  = 3'(fifo_count) - 3'(src_xfer) + 3'(inflight);
  assign issue  = stream_phase && (iss_cnt < phase_words) && (level < 3'd2);
  assign mem_re = issue;

  stream_skid_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (src_xfer),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = PRM;
      PRM:     if (last_xfer) state_nx = GAP;
      GAP:     state_nx = (nbatch_q == 8'd0) ? FIN : SRC;
      SRC:     if (last_xfer) state_nx = DRAIN;
      DRAIN:   if (last_wr) state_nx = ((b_cnt + 8'd1) < nbatch_q) ? SRC : FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    matw      = (state == PRM);
    run       = (state == SRC) || (state == DRAIN);
    mem_raddr = issue ? rd_ptr : '0;
    mem_we    = wr_fire;
    mem_waddr = wr_fire ? wr_ptr : '0;
    mem_wdata = wr_fire ? dst_data : '0;
    src_data  = src_valid ? fifo_head : '0;
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      nbatch_q   <= 8'd0;
      b_cnt      <= 8'd0;
      src_base_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      iss_cnt    <= '0;
      acc_cnt    <= '0;
      dst_cnt    <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (state == IDLE && start) begin
        nbatch_q   <= nbatch;
        src_base_q <= src_base;
        rd_ptr     <= prm_base;
        wr_ptr     <= dst_base;
        b_cnt      <= 8'd0;
      end
      if (issue) begin
        rd_ptr  <= rd_ptr + AW'(1);
        iss_cnt <= iss_cnt + WCNT_W'(1);
      end
      if (src_xfer) acc_cnt <= acc_cnt + WCNT_W'(1);
      if (last_xfer) begin
        iss_cnt <= '0;
        acc_cnt <= '0;
      end
      // Batches are contiguous, so the source pointer just keeps running
      // across DRAIN -> SRC; only the first batch needs the base reloaded.
      if (state == GAP) rd_ptr <= src_base_q;
      if (wr_fire) begin
        wr_ptr  <= wr_ptr + AW'(1);
        dst_cnt <= dst_cnt + DCNT_W'(1);
      end
      if (last_wr) begin
        dst_cnt <= '0;
        b_cnt   <= b_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gemm_stream_master.sv
// Directed bench for gemm_stream_master: word memory model, stream drivers,
// a negedge monitor logging traffic, and one task per scenario.
module tb_gemm_stream_master;
  import gemm_stream_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    nbatch = 8'd0;
  logic [AW-1:0] prm_base = '0, src_base = '0, dst_base = '0;
  logic          busy, done, mem_re, mem_we, matw, run, src_valid, dst_ready;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_rdata, mem_wdata, src_data, dst_data;
  logic          src_ready, dst_valid;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gemm_stream_master #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .nbatch(nbatch),
    .prm_base(prm_base), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .matw(matw), .run(run), .src_valid(src_valid),
    .src_ready(src_ready), .src_data(src_data), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .dst_data(dst_data), .dbg_state(dbg_state)
  );

  // Word memory: read data one cycle after the strobe; content tags the address.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_raddr];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA000_0000 | {20'd0, a};
  endfunction

  // Stream drivers: src_ready by mode, dst_valid by enable, dst_data = D0000000+k.
  int ready_mode = 0;
  logic dst_en = 1'b1;
  int dst_seq = 0;
  logic hs;
  initial begin
    src_ready = 1'b0; dst_valid = 1'b0; dst_data = '0;
    forever begin
      @(negedge clk);
      hs = dst_valid && dst_ready;
      @(posedge clk); #1;
      if (hs) dst_seq++;
      else if (!busy) dst_seq = 0;
      dst_data  = 32'hD000_0000 + 32'(dst_seq);
      dst_valid = dst_en;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'($urandom_range(0, 1));
        default: src_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  logic [DW-1:0] src_q[$];
  logic          matw_q[$];
  logic [AW-1:0] raddr_q[$];
  logic [AW-1:0] waddr_q[$];
  logic [DW-1:0] wdata_q[$];
  int cyc = 0, done_cnt, run_rises, run_cycles, gap_cycles, stab_err, outst_err;
  int valid_err, stall_cycles, nprm, first_prm, last_prm, issued, accepted;
  logic prev_run, prev_stall;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_run = 1'b0; prev_stall = 1'b0; issued = 0; accepted = 0;
    end else begin
      if (prev_stall && (src_valid !== 1'b1 || src_data !== prev_data)) stab_err++;
      if (src_valid && !(matw || run)) valid_err++;
      if (src_valid && !src_ready) stall_cycles++;
      if (mem_re) begin raddr_q.push_back(mem_raddr); issued++; end
      if (src_valid && src_ready) begin
        src_q.push_back(src_data); matw_q.push_back(matw); accepted++;
        if (matw) begin
          if (nprm == 0) first_prm = cyc;
          last_prm = cyc; nprm++;
        end
      end
      if (issued - accepted > 2) outst_err++;
      if (mem_we) begin waddr_q.push_back(mem_waddr); wdata_q.push_back(mem_wdata); end
      if (done) done_cnt++;
      if (run && !prev_run) run_rises++;
      if (run) run_cycles++;
      if (busy && !matw && !run && !done) gap_cycles++;
      prev_run = run; prev_stall = src_valid && !src_ready; prev_data = src_data;
    end
  end

  task automatic clear_logs();
    src_q.delete(); matw_q.delete(); raddr_q.delete(); waddr_q.delete(); wdata_q.delete();
    done_cnt = 0; run_rises = 0; run_cycles = 0; gap_cycles = 0; stab_err = 0;
    outst_err = 0; valid_err = 0; stall_cycles = 0; nprm = 0; first_prm = 0; last_prm = 0;
  endtask

  task automatic start_cmd(input int nb, input int pb, input int sb, input int db);
    @(posedge clk); #1;
    clear_logs();
    nbatch = 8'(nb); prm_base = AW'(pb); src_base = AW'(sb); dst_base = AW'(db);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, or flags a timeout.
  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    logic [95:0] ov;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    ov = {busy, done, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
          matw, run, src_valid, src_data, dst_ready};
    n_tests++;
    if (ov !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", ov); end
    n_tests++;
    if (dbg_state !== 3'(IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit to;
    logic [AW-1:0] ea;
    ready_mode = 0;
    start_cmd(1, 100, 200, 1000);
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL single_timeout: got no done want done"); end
    @(negedge clk); #1;
    n_tests++;
    if (src_q.size() != 64) begin n_fail++; $display("FAIL single_src_count: got %0d want 64", src_q.size()); end
    for (int i = 0; i < 64; i++) begin
      ea = (i < 32) ? AW'(100 + i) : AW'(200 + i - 32);
      n_tests++;
      if (i >= src_q.size() || src_q[i] !== mem_word(ea) || matw_q[i] !== (i < 32)) begin
        n_fail++; $display("FAIL single_src[%0d]: got %h want %h", i, src_q[i], mem_word(ea));
      end
      n_tests++;
      if (i >= raddr_q.size() || raddr_q[i] !== ea) begin
        n_fail++; $display("FAIL single_raddr[%0d]: got %0d want %0d", i, raddr_q[i], ea);
      end
    end
    n_tests++;
    if (waddr_q.size() != 16) begin n_fail++; $display("FAIL single_wr_count: got %0d want 16", waddr_q.size()); end
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (k >= waddr_q.size() || waddr_q[k] !== AW'(1000 + k) || wdata_q[k] !== 32'hD000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL single_wr[%0d]: got %0d/%h want %0d/%h", k, waddr_q[k], wdata_q[k], 1000 + k, 32'hD000_0000 + 32'(k));
      end
    end
    n_tests++;
    if (last_prm - first_prm != 31) begin n_fail++; $display("FAIL single_prm_rate: got span %0d want 31", last_prm - first_prm); end
    n_tests++;
    if (gap_cycles != 1) begin n_fail++; $display("FAIL single_gap: got %0d want 1", gap_cycles); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL single_after: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_multi();
    bit to;
    ready_mode = 1;
    start_cmd(3, 300, 500, 2000);
    repeat (50) @(posedge clk);
    #1; start = 1'b1; nbatch = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL multi_timeout: got no done want done"); end
    @(negedge clk); #1;
    ready_mode = 0;
    n_tests++;
    if (src_q.size() != 128) begin n_fail++; $display("FAIL multi_src_count: got %0d want 128", src_q.size()); end
    for (int i = 0; i < 96; i++) begin
      n_tests++;
      if (32 + i >= src_q.size() || src_q[32 + i] !== mem_word(AW'(500 + i))) begin
        n_fail++; $display("FAIL multi_src[%0d]: got %h want %h", i, src_q[32 + i], mem_word(AW'(500 + i)));
      end
    end
    n_tests++;
    if (waddr_q.size() != 48) begin n_fail++; $display("FAIL multi_wr_count: got %0d want 48", waddr_q.size()); end
    for (int k = 0; k < 48; k++) begin
      n_tests++;
      if (k >= waddr_q.size() || waddr_q[k] !== AW'(2000 + k) || wdata_q[k] !== 32'hD000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL multi_wr[%0d]: got %0d/%h want %0d", k, waddr_q[k], wdata_q[k], 2000 + k);
      end
    end
    n_tests++;
    if (run_rises != 1) begin n_fail++; $display("FAIL multi_run_continuous: got %0d rises want 1", run_rises); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL multi_done_count: got %0d want 1", done_cnt); end
    n_tests++;
    if (stab_err != 0 || valid_err != 0 || outst_err != 0) begin
      n_fail++; $display("FAIL multi_handshake: got stab=%0d valid=%0d outst=%0d want 0", stab_err, valid_err, outst_err);
    end
  endtask

  task automatic test_zero();
    bit to;
    start_cmd(0, 40, 0, 0);
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL zero_timeout: got no done want done"); end
    // start coinciding with done must be ignored
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 3'(IDLE)) begin n_fail++; $display("FAIL zero_start_on_done: got busy=%b state=%0d want 0/0", busy, dbg_state); end
    n_tests++;
    if (src_q.size() != 32 || run_cycles != 0 || waddr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_shape: got src=%0d run=%0d wr=%0d want 32/0/0", src_q.size(), run_cycles, waddr_q.size());
    end
    n_tests++;
    if (gap_cycles != 1 || done_cnt != 1) begin n_fail++; $display("FAIL zero_gap_done: got gap=%0d done=%0d want 1/1", gap_cycles, done_cnt); end
  endtask

  task automatic test_stall();
    bit to;
    ready_mode = 0;
    start_cmd(0, 700, 0, 0);
    for (int i = 0; i < 200 && nprm < 10; i++) @(negedge clk);
    ready_mode = 2;
    repeat (10) @(negedge clk);
    ready_mode = 0;
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
    @(negedge clk); #1;
    n_tests++;
    if (stall_cycles < 8) begin n_fail++; $display("FAIL stall_seen: got %0d stalled cycles want >=8", stall_cycles); end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
    n_tests++;
    if (outst_err != 0) begin n_fail++; $display("FAIL stall_outstanding: got %0d overflows want 0", outst_err); end
    n_tests++;
    if (src_q.size() != 32) begin n_fail++; $display("FAIL stall_count: got %0d want 32", src_q.size()); end
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (i >= src_q.size() || src_q[i] !== mem_word(AW'(700 + i))) begin
        n_fail++; $display("FAIL stall_src[%0d]: got %h want %h", i, src_q[i], mem_word(AW'(700 + i)));
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [AW-1:0] ea;
    start_cmd(0, 4092, 0, 0);
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL wrap_timeout: got no done want done"); end
    @(negedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      ea = (i < 4) ? AW'(4092 + i) : AW'(i - 4);
      n_tests++;
      if (i >= raddr_q.size() || raddr_q[i] !== ea || src_q[i] !== mem_word(ea)) begin
        n_fail++; $display("FAIL wrap[%0d]: got %0d/%h want %0d/%h", i, raddr_q[i], src_q[i], ea, mem_word(ea));
      end
    end
    n_tests++;
    if (run_cycles != 0) begin n_fail++; $display("FAIL wrap_run: got %0d run cycles want 0", run_cycles); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int nwr;
    logic [95:0] ov;
    start_cmd(2, 0, 100, 3000);
    nwr = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mem_we) nwr++;
      if (nwr == 5) break;
    end
    n_tests++;
    if (nwr != 5) begin n_fail++; $display("FAIL rmid_reach: got %0d writes want 5", nwr); end
    reset = 1'b1;
    @(negedge clk); #1;
    ov = {busy, done, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
          matw, run, src_valid, src_data, dst_ready};
    n_tests++;
    if (ov !== '0 || dbg_state !== 3'(IDLE)) begin n_fail++; $display("FAIL rmid_outputs: got %h state %0d want 0/0", ov, dbg_state); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got done=%0d busy=%b want 0/0", done_cnt, busy); end
    start_cmd(1, 50, 60, 3100);
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL rmid_restart_timeout: got no done want done"); end
    @(negedge clk); #1;
    n_tests++;
    if (src_q.size() != 64 || waddr_q.size() != 16) begin
      n_fail++; $display("FAIL rmid_restart_shape: got src=%0d wr=%0d want 64/16", src_q.size(), waddr_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (32 + i >= src_q.size() || src_q[32 + i] !== mem_word(AW'(60 + i))) begin
        n_fail++; $display("FAIL rmid_src[%0d]: got %h want %h", i, src_q[32 + i], mem_word(AW'(60 + i)));
      end
    end
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (k >= waddr_q.size() || waddr_q[k] !== AW'(3100 + k) || wdata_q[k] !== 32'hD000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL rmid_wr[%0d]: got %0d/%h want %0d", k, waddr_q[k], wdata_q[k], 3100 + k);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
    clear_logs();
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
